// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file / write-back definitions: sizes, scoreboard counter width,
// and the WB-stage RegWriteSrc encodings.
package regfile_scoreboard_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned CNT_W     = 2;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RWS_ALU = 2'd0,
        RWS_MEM = 2'd1,
        RWS_PC  = 2'd2
    } reg_write_src_e;

    // One-hot select of a register index, used for the per-register counter events.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input reg_idx_t idx);
        logic [NUM_REGS-1:0] oh;
        oh      = '0;
        oh[idx] = en;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter: one increment and two decrement events
// combine as a net sum per cycle; err pulses when the net result leaves [0, max].
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec_a,
    input  logic             dec_b,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   up_sum;
    logic [CNT_W:0]   dn_sum;
    logic [CNT_W:0]   net;

    always_comb begin
        up_sum = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
        dn_sum = {{CNT_W{1'b0}}, dec_a} + {{CNT_W{1'b0}}, dec_b};
        net    = up_sum - dn_sum;
        cnt_d  = net[CNT_W-1:0];
        err    = 1'b0;
        if (up_sum < dn_sum) begin
            cnt_d = '0;
            err   = 1'b1;
        end else if (net > CNT_MAX) begin
            cnt_d = '1;
            err   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// 4x16 architectural register file with WB write port, two combinational ID read
// ports and a per-register pending-write scoreboard. Optional macro: REGFILE_BYPASS_EN.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic                 rs1_used,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic                 rs2_used,
    output logic [WORD_SIZE-1:0] read_data1,
    output logic [WORD_SIZE-1:0] read_data2,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_target,
    input  logic                 wb_regwrite,
    input  logic [REG_IDX_W-1:0] wb_target,
    input  logic [WORD_SIZE-1:0] wb_data,
    input  logic                 kill_valid,
    input  logic [REG_IDX_W-1:0] kill_target,
    output logic                 stall,
    output logic                 sb_error
);

    word_t            regs_q [NUM_REGS];
    logic [CNT_W-1:0] cnt    [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec, wb_vec, kill_vec, err_vec;
    logic sb_error_q, sb_error_d;
    logic haz1, haz2;

    assign inc_vec  = reg_onehot(issue_valid, issue_target);
    assign wb_vec   = reg_onehot(wb_regwrite, wb_target);
    assign kill_vec = reg_onehot(kill_valid, kill_target);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (inc_vec[g]),
            .dec_a   (wb_vec[g]),
            .dec_b   (kill_vec[g]),
            .cnt     (cnt[g]),
            .err     (err_vec[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: '0};
        end else if (wb_regwrite) begin
            regs_q[wb_target] <= wb_data;
        end
    end

    assign sb_error_d = sb_error_q | (|err_vec);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_error_q <= 1'b0;
        end else begin
            sb_error_q <= sb_error_d;
        end
    end

    always_comb begin
        read_data1 = regs_q[rs1];
        read_data2 = regs_q[rs2];
        haz1       = rs1_used && (cnt[rs1] != '0);
        haz2       = rs2_used && (cnt[rs2] != '0);
`ifdef REGFILE_BYPASS_EN
        // A retiring last writer satisfies the read this cycle via the bypass.
        if (wb_regwrite && (wb_target == rs1)) begin
            read_data1 = wb_data;
            if (cnt[rs1] == CNT_W'(1)) haz1 = 1'b0;
        end
        if (wb_regwrite && (wb_target == rs2)) begin
            read_data2 = wb_data;
            if (cnt[rs2] == CNT_W'(1)) haz2 = 1'b0;
        end
`endif
        stall = haz1 | haz2;
    end

    assign sb_error = sb_error_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: queue-based scoreboard against a
// behavioural model, plus directed reset/hazard/saturation cases.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rs1 = '0, rs2 = '0, issue_target = '0, wb_target = '0, kill_target = '0;
    logic        rs1_used = 1'b0, rs2_used = 1'b0, issue_valid = 1'b0, wb_regwrite = 1'b0, kill_valid = 1'b0;
    logic [15:0] wb_data = '0;
    logic [15:0] read_data1, read_data2;
    logic        stall, sb_error;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        bit          stall;
        bit          err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [15:0] m_reg [4];
    int          m_cnt [4];
    bit          m_err;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_scoreboard dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rs1          (rs1),
        .rs1_used     (rs1_used),
        .rs2          (rs2),
        .rs2_used     (rs2_used),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .issue_valid  (issue_valid),
        .issue_target (issue_target),
        .wb_regwrite  (wb_regwrite),
        .wb_target    (wb_target),
        .wb_data      (wb_data),
        .kill_valid   (kill_valid),
        .kill_target  (kill_target),
        .stall        (stall),
        .sb_error     (sb_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [15:0] model_read(input int rs, input bit wv, input int wt, input logic [15:0] wd);
        if (BYPASS && wv && wt == rs) return wd;
        return m_reg[rs];
    endfunction

    function automatic bit model_haz(input int rs, input bit used, input bit wv, input int wt);
        if (!used || m_cnt[rs] == 0) return 1'b0;
        if (BYPASS && wv && wt == rs && m_cnt[rs] == 1) return 1'b0;
        return 1'b1;
    endfunction

    // One clock cycle: drive at negedge, queue the expected response, advance the model.
    task automatic cycle(input bit iv, input int it, input bit wv, input int wt, input logic [15:0] wd,
                         input bit kv, input int kt, input int r1, input bit u1, input int r2, input bit u2);
        exp_t e;
        int   net;
        @(negedge clk);
        issue_valid = iv; issue_target = it[1:0];
        wb_regwrite = wv; wb_target = wt[1:0]; wb_data = wd;
        kill_valid = kv; kill_target = kt[1:0];
        rs1 = r1[1:0]; rs1_used = u1; rs2 = r2[1:0]; rs2_used = u2;
        e.rd1   = model_read(r1, wv, wt, wd);
        e.rd2   = model_read(r2, wv, wt, wd);
        e.stall = model_haz(r1, u1, wv, wt) | model_haz(r2, u2, wv, wt);
        e.err   = m_err;
        exp_q.push_back(e);
        for (int r = 0; r < 4; r++) begin
            net = m_cnt[r] + int'(iv && it == r) - int'(wv && wt == r) - int'(kv && kt == r);
            if (net > 3) begin
                m_cnt[r] = 3; m_err = 1'b1;
            end else if (net < 0) begin
                m_cnt[r] = 0; m_err = 1'b1;
            end else begin
                m_cnt[r] = net;
            end
        end
        if (wv) m_reg[wt] = wd;
    endtask

    task automatic idle(input int r1, input bit u1, input int r2, input bit u2);
        cycle(0, 0, 0, 0, 16'h0, 0, 0, r1, u1, r2, u2);
    endtask

    // Asynchronous reset pulse between clock edges, with immediate output checks.
    task automatic mid_reset(input int r1, input bit u1, input bit exp_stall_before);
        idle(r1, u1, 0, 0);
        #3;
        chk("stall_before_reset", {31'b0, stall}, {31'b0, exp_stall_before});
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_rd1", {16'b0, read_data1}, 32'd0);
        chk("reset_err", {31'b0, sb_error}, 32'd0);
        reset_n = 1'b1;
    endtask

    // Monitor: every cycle with a queued expectation, compare the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_rd1", {16'b0, read_data1}, {16'b0, e.rd1});
                chk("sb_rd2", {16'b0, read_data2}, {16'b0, e.rd2});
                chk("sb_stall", {31'b0, stall}, {31'b0, e.stall});
                chk("sb_err", {31'b0, sb_error}, {31'b0, e.err});
            end
        end
    end

    initial begin
        int it, wt, kt, r1, r2, cand;
        bit iv, wv, kv, u1, u2;
        model_reset();
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;

        // Reset state, read regs 2/3
        mid_reset(2, 1, 1'b0);
        cycle(0, 0, 0, 0, 16'h0, 0, 0, 2, 1, 3, 1);
        #1 chk("rst_read", {read_data1, read_data2}, 32'd0);

        // Write/read (no pending write: this also sets sb_error, so reset afterwards)
        cycle(0, 0, 1, 1, 16'hBEEF, 0, 0, 0, 0, 0, 0);
        idle(1, 1, 2, 1);
        #1 chk("beef_read", {read_data1, read_data2}, {16'hBEEF, 16'h0000});
        mid_reset(0, 0, 1'b0);

        // RAW stall on reg 2, retire at cycle 3
        cycle(1, 2, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        idle(2, 1, 0, 0);
        #1 chk("raw_c1", {31'b0, stall}, 32'd1);
        idle(2, 1, 0, 0);
        cycle(0, 0, 1, 2, 16'h1234, 0, 0, 2, 1, 0, 0);
        #1 chk("raw_c3_stall", {31'b0, stall}, BYPASS ? 32'd0 : 32'd1);
        if (BYPASS) chk("raw_c3_bypass", {16'b0, read_data1}, 32'h1234);
        idle(2, 1, 0, 0);
        #1 chk("raw_c4", {read_data1, 15'b0, stall}, {16'h1234, 16'h0});

        // Simultaneous issue+retire on reg 3, then kill
        cycle(1, 3, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        cycle(1, 3, 1, 3, 16'h0033, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 3, 1);
        #1 chk("simul_stall", {31'b0, stall}, 32'd1);
        cycle(0, 0, 0, 0, 16'h0, 1, 3, 0, 0, 3, 1);
        idle(0, 0, 3, 1);
        #1 chk("kill_clear", {30'b0, stall, sb_error}, 32'd0);

        // Overflow on reg 0
        repeat (4) cycle(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        idle(0, 1, 0, 0);
        #1 chk("overflow_err", {31'b0, sb_error}, 32'd1);
        mid_reset(0, 1, 1'b1);

        // Underflow on reg 1
        cycle(0, 0, 1, 1, 16'h5555, 0, 0, 0, 0, 0, 0);
        idle(1, 1, 0, 0);
        #1 chk("underflow", {30'b0, stall, sb_error}, 32'd1);
        mid_reset(0, 0, 1'b0);

        // Async reset with two pending writes to reg 1
        repeat (2) cycle(1, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        mid_reset(1, 1, 1'b1);

        // Constrained random traffic that respects the environment contract
        for (int n = 0; n < 600; n++) begin
            r1 = $urandom_range(3); r2 = $urandom_range(3);
            u1 = $urandom_range(1); u2 = $urandom_range(1);
            wv = 0; wt = 0; kv = 0; kt = 0;
            cand = $urandom_range(3);
            if (m_cnt[cand] > 0 && $urandom_range(2) != 0) begin
                wv = 1; wt = cand;
            end
            cand = $urandom_range(3);
            if ((m_cnt[cand] - int'(wv && wt == cand)) > 0 && $urandom_range(4) == 0) begin
                kv = 1; kt = cand;
            end
            it = $urandom_range(3);
            iv = ($urandom_range(1) == 1) && !(model_haz(r1, u1, wv, wt) | model_haz(r2, u2, wv, wt))
                 && (m_cnt[it] - int'(wv && wt == it) - int'(kv && kt == it)) < 3;
            cycle(iv, it, wv, wt, 16'($urandom), kv, kt, r1, u1, r2, u2);
        end

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
